// File: rtl/fifo_1c_ext_pkg.sv
// Shared types and elaboration helpers for the extended single-clock FIFO.
package fifo_1c_ext_pkg;

  typedef enum logic {
    RD_STD  = 1'b0,
    RD_FWFT = 1'b1
  } rd_mode_e;

  function automatic rd_mode_e mode_of(input int fwft);
    return (fwft != 0) ? RD_FWFT : RD_STD;
  endfunction

  function automatic bit thresholds_ok(input int aw, input int unsigned afull_th,
                                       input int unsigned aempty_th);
    return (afull_th <= (32'd1 << aw)) && (aempty_th < (32'd1 << aw));
  endfunction

endpackage

// File: rtl/fifo_1c_ext_if.sv
// Client-side bus of fifo_1c_ext: write/read requests, data, status and error flags.
interface fifo_1c_ext_if #(
  parameter int dw = 16,
  parameter int aw = 8
);
  logic [dw-1:0] din;
  logic          we;
  logic          re;
  logic          clr_err;
  logic [dw-1:0] dout;
  logic          valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [aw:0]   count;
  logic          overflow;
  logic          underflow;

  modport master (
    output din, we, re, clr_err,
    input  dout, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  din, we, re, clr_err,
    output dout, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/dpram.sv
// Simple dual-port RAM: port a writes, port b reads with one cycle of latency.
module dpram #(
  parameter int aw = 8,
  parameter int dw = 16
) (
  input  logic          i_clk,
  input  logic          i_we_a,
  input  logic [aw-1:0] i_addr_a,
  input  logic [dw-1:0] i_din_a,
  input  logic          i_re_b,
  input  logic [aw-1:0] i_addr_b,
  output logic [dw-1:0] o_dout_b
);
  logic [dw-1:0] r_mem [2**aw];
  logic [dw-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we_a) r_mem[i_addr_a] <= i_din_a;
    if (i_re_b) r_q <= r_mem[i_addr_b];
  end

  assign o_dout_b = r_q;
endmodule

// File: rtl/fifo_1c_ext_ctl.sv
// Pointer, occupancy, status-flag and sticky-error control shared by both read modes.
module fifo_1c_ext_ctl
  import fifo_1c_ext_pkg::*;
#(
  parameter int          aw        = 8,
  parameter int          fwft      = 0,
  parameter int unsigned afull_th  = 2**aw - 2,
  parameter int unsigned aempty_th = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic          i_re,
  input  logic          i_clr_err,
  input  logic          i_rd_adv,
  input  logic          i_valid_next,
  output logic          o_wacc,
  output logic          o_racc,
  output logic [aw-1:0] o_waddr,
  output logic [aw-1:0] o_raddr,
  output logic          o_ram_ne,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_almost_full,
  output logic          o_almost_empty,
  output logic [aw:0]   o_count,
  output logic          o_overflow,
  output logic          o_underflow
);
  localparam rd_mode_e    MODE      = mode_of(fwft);
  localparam logic [aw:0] CAP       = {1'b1, {aw{1'b0}}};
  localparam logic [aw:0] AFULL_TH  = (aw+1)'(afull_th);
  localparam logic [aw:0] AEMPTY_TH = (aw+1)'(aempty_th);

  logic [aw:0] r_wp, r_rp, r_count;
  logic        r_full, r_empty, r_afull, r_aempty, r_ovf, r_udf;
  logic        w_wacc, w_racc, w_empty_next;
  logic [aw:0] w_count_next;

  assign w_wacc       = i_we & ~r_full;
  assign w_racc       = i_re & ~r_empty;
  assign w_count_next = r_count + (aw+1)'(w_wacc) - (aw+1)'(w_racc);
  // In FWFT mode "empty" tracks the output stage, not the word count.
  assign w_empty_next = (MODE == RD_FWFT) ? ~i_valid_next : (w_count_next == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wacc)   r_wp <= r_wp + (aw+1)'(1);
      if (i_rd_adv) r_rp <= r_rp + (aw+1)'(1);
      r_count  <= w_count_next;
      r_full   <= (w_count_next == CAP);
      r_empty  <= w_empty_next;
      r_afull  <= (w_count_next >= AFULL_TH);
      r_aempty <= (w_count_next <= AEMPTY_TH);
      if (i_we && r_full)       r_ovf <= 1'b1;
      else if (i_clr_err)       r_ovf <= 1'b0;
      if (i_re && r_empty)      r_udf <= 1'b1;
      else if (i_clr_err)       r_udf <= 1'b0;
    end
  end

  assign o_wacc         = w_wacc;
  assign o_racc         = w_racc;
  assign o_waddr        = r_wp[aw-1:0];
  assign o_raddr        = r_rp[aw-1:0];
  assign o_ram_ne       = (r_wp != r_rp);
  assign o_full         = r_full;
  assign o_empty        = r_empty;
  assign o_almost_full  = r_afull;
  assign o_almost_empty = r_aempty;
  assign o_count        = r_count;
  assign o_overflow     = r_ovf;
  assign o_underflow    = r_udf;
endmodule

// File: rtl/fifo_1c_ext.sv
// Single-clock FIFO with optional first-word-fall-through output, threshold flags,
// occupancy count and sticky overflow/underflow.
module fifo_1c_ext
  import fifo_1c_ext_pkg::*;
#(
  parameter int          dw        = 16,
  parameter int          aw        = 8,
  parameter int          fwft      = 0,
  parameter int unsigned afull_th  = 2**aw - 2,
  parameter int unsigned aempty_th = 2
) (
  input logic           clk,
  input logic           rst_n,
  fifo_1c_ext_if.slave  bus
);
  localparam rd_mode_e MODE = mode_of(fwft);

  if (!thresholds_ok(aw, afull_th, aempty_th)) begin : g_bad_th
    $error("fifo_1c_ext: afull_th must be <= 2**aw and aempty_th < 2**aw");
  end

  logic          w_wacc, w_racc, w_ram_ne, w_rd_adv, w_valid_next;
  logic [aw-1:0] w_waddr, w_raddr;
  logic [dw-1:0] w_ram_q;
  logic          r_valid;
  logic [dw-1:0] r_dout;

  fifo_1c_ext_ctl #(
    .aw        (aw),
    .fwft      (fwft),
    .afull_th  (afull_th),
    .aempty_th (aempty_th)
  ) u_ctl (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_we           (bus.we),
    .i_re           (bus.re),
    .i_clr_err      (bus.clr_err),
    .i_rd_adv       (w_rd_adv),
    .i_valid_next   (w_valid_next),
    .o_wacc         (w_wacc),
    .o_racc         (w_racc),
    .o_waddr        (w_waddr),
    .o_raddr        (w_raddr),
    .o_ram_ne       (w_ram_ne),
    .o_full         (bus.full),
    .o_empty        (bus.empty),
    .o_almost_full  (bus.almost_full),
    .o_almost_empty (bus.almost_empty),
    .o_count        (bus.count),
    .o_overflow     (bus.overflow),
    .o_underflow    (bus.underflow)
  );

  dpram #(
    .aw (aw),
    .dw (dw)
  ) u_ram (
    .i_clk    (clk),
    .i_we_a   (w_wacc),
    .i_addr_a (w_waddr),
    .i_din_a  (bus.din),
    .i_re_b   (w_rd_adv),
    .i_addr_b (w_raddr),
    .o_dout_b (w_ram_q)
  );

  if (MODE == RD_FWFT) begin : g_fwft
    logic r_q_vld;
    logic w_xfer;

    // RAM output acts as a hidden skid stage feeding the head register, so
    // streaming pops can refill the head every cycle.
    assign w_xfer       = r_q_vld & (~r_valid | w_racc);
    assign w_rd_adv     = w_ram_ne & (~r_q_vld | w_xfer);
    assign w_valid_next = w_xfer | (r_valid & ~w_racc);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_q_vld <= 1'b0;
        r_valid <= 1'b0;
      end else begin
        r_q_vld <= w_rd_adv | (r_q_vld & ~w_xfer);
        r_valid <= w_valid_next;
      end
    end

    always_ff @(posedge clk) begin
      if (w_xfer) r_dout <= w_ram_q;
    end
  end else begin : g_std
    logic r_rd_d1;

    assign w_rd_adv     = w_racc;
    assign w_valid_next = 1'b0;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_rd_d1 <= 1'b0;
        r_valid <= 1'b0;
      end else begin
        r_rd_d1 <= w_racc;
        r_valid <= r_rd_d1;
      end
    end

    always_ff @(posedge clk) begin
      if (r_rd_d1) r_dout <= w_ram_q;
    end
  end

  assign bus.dout  = r_dout;
  assign bus.valid = r_valid;
endmodule
